// File: rtl/debounce_pkg.sv
// debounce_pkg
//   Shared definitions for the debounce bank: per-channel FSM state
//   encoding and width helpers for the tick counter and the prescaler.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } ch_state_e;

  // Bits needed to hold 0..hold_ticks in the per-channel counter.
  function automatic int unsigned tick_cnt_width(input int unsigned hold_ticks);
    return (hold_ticks < 1) ? 1 : $clog2(hold_ticks + 1);
  endfunction

  // Bits needed to count 0..div-1 in the shared prescaler.
  function automatic int unsigned prescale_width(input int unsigned div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
//   One button channel: optional inversion, 2-flop synchroniser, and a
//   four-state qualify FSM that accepts a level change only after the
//   synchronised input has held the new level for HOLD_TICKS ticks.
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   tick        one-cycle enable from the shared prescaler
//   raw         asynchronous raw button level
//   level       registered debounced level
//   rise, fall  one-cycle pulses aligned with the first cycle of a new level
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned HOLD_TICKS = 300,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned    CW       = tick_cnt_width(HOLD_TICKS);
  localparam logic [CW-1:0]  HOLD_MAX = CW'(HOLD_TICKS);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  ch_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;
  logic            level_q, level_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  always_comb begin
    sync1_d = raw ^ ACTIVE_LOW;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + CW'(1);

    // A reversal of the synchronised input is tested before the tick, so it
    // wins even on the cycle that would otherwise complete the count.
    unique case (state_q)
      ST_LOW: begin
        if (sync2_q) begin
          state_d = ST_WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      ST_WAIT_HIGH: begin
        if (!sync2_q) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_inc == HOLD_MAX) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_HIGH: begin
        if (!sync2_q) begin
          state_d = ST_WAIT_LOW;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOW: begin
        if (sync2_q) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_inc == HOLD_MAX) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so that level and the
    // edge pulses change together on the accepting edge.
    level_d = (state_d == ST_HIGH) || (state_d == ST_WAIT_LOW);
    rise_d  = (state_q == ST_WAIT_HIGH) && (state_d == ST_HIGH);
    fall_d  = (state_q == ST_WAIT_LOW) && (state_d == ST_LOW);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank
//   Bank of N_CH independent button debouncers sharing one tick prescaler.
// Ports:
//   Clk          system clock, rising edge
//   Reset        asynchronous active-high reset
//   boton_raw    raw asynchronous button levels, one bit per channel
//   boton_level  debounced level per channel
//   boton_rise   one-cycle pulse on an accepted 0->1 change
//   boton_fall   one-cycle pulse on an accepted 1->0 change
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned HOLD_TICKS = 300,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [N_CH-1:0] boton_raw,
  output logic [N_CH-1:0] boton_level,
  output logic [N_CH-1:0] boton_rise,
  output logic [N_CH-1:0] boton_fall
);

  localparam int unsigned   PW       = prescale_width(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + PW'(1);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .HOLD_TICKS (HOLD_TICKS),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk   (Clk),
      .rst   (Reset),
      .tick  (tick),
      .raw   (boton_raw[g]),
      .level (boton_level[g]),
      .rise  (boton_rise[g]),
      .fall  (boton_fall[g])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank
//   Two instances (active-high and active-low inputs) run in lock-step with
//   a window-based reference model; directed scenarios then random toggling.
module tb_debounce_bank;

  localparam int unsigned N  = 4;
  localparam int unsigned TD = 4;
  localparam int unsigned HT = 3;

  logic         Clk   = 1'b0;
  logic         Reset = 1'b0;
  logic [N-1:0] raw_a = '0;
  logic [N-1:0] raw_b = '0;
  logic [N-1:0] lvl_a, rise_a, fall_a;
  logic [N-1:0] lvl_b, rise_b, fall_b;

  always #5 Clk = ~Clk;

  debounce_bank #(
    .N_CH       (N),
    .TICK_DIV   (TD),
    .HOLD_TICKS (HT),
    .ACTIVE_LOW (1'b0)
  ) u_dut_a (
    .Clk         (Clk),
    .Reset       (Reset),
    .boton_raw   (raw_a),
    .boton_level (lvl_a),
    .boton_rise  (rise_a),
    .boton_fall  (fall_a)
  );

  debounce_bank #(
    .N_CH       (N),
    .TICK_DIV   (TD),
    .HOLD_TICKS (HT),
    .ACTIVE_LOW (1'b1)
  ) u_dut_b (
    .Clk         (Clk),
    .Reset       (Reset),
    .boton_raw   (raw_b),
    .boton_level (lvl_b),
    .boton_rise  (rise_b),
    .boton_fall  (fall_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: a channel flips once its synchronised input has
  // disagreed with the accepted level continuously, and HT ticks have
  // occurred strictly after the first cycle of disagreement.
  bit m_lvl  [2][N];
  bit m_wait [2][N];
  int m_start[2][N];
  bit m_s1   [2][N];
  bit m_s2   [2][N];
  bit m_rise [2][N];
  bit m_fall [2][N];
  int m_cyc;
  int rise_cnt[2][N];
  int fall_cnt[2][N];

  // Number of tick edges among edges 0..k (tick when k mod TD == TD-1).
  function automatic int ticks_upto(input int k);
    return (k + 1) / TD;
  endfunction

  task automatic model_predict();
    logic [N-1:0] r;
    bit s;
    for (int d = 0; d < 2; d++) begin
      r = (d == 1) ? raw_b : raw_a;
      for (int c = 0; c < N; c++) begin
        m_rise[d][c] = 1'b0;
        m_fall[d][c] = 1'b0;
        if (Reset) begin
          m_lvl[d][c] = 1'b0; m_wait[d][c] = 1'b0; m_start[d][c] = 0;
          m_s1[d][c]  = 1'b0; m_s2[d][c]   = 1'b0;
        end else begin
          s = m_s2[d][c];
          if (s == m_lvl[d][c]) begin
            m_wait[d][c] = 1'b0;
          end else if (!m_wait[d][c]) begin
            m_wait[d][c]  = 1'b1;
            m_start[d][c] = m_cyc;
          end else if (ticks_upto(m_cyc) - ticks_upto(m_start[d][c]) >= int'(HT)) begin
            m_lvl[d][c]  = s;
            m_wait[d][c] = 1'b0;
            if (s) m_rise[d][c] = 1'b1;
            else   m_fall[d][c] = 1'b1;
          end
          m_s2[d][c] = m_s1[d][c];
          m_s1[d][c] = r[c] ^ (d == 1);
        end
      end
    end
    m_cyc = Reset ? 0 : m_cyc + 1;
  endtask

  function automatic logic [N-1:0] pack_bits(input int d, input int sel);
    logic [N-1:0] v;
    v = '0;
    for (int c = 0; c < N; c++)
      v[c] = (sel == 0) ? m_lvl[d][c] : (sel == 1) ? m_rise[d][c] : m_fall[d][c];
    return v;
  endfunction

  // One clock: predict the coming edge, then compare on the falling edge.
  task automatic step();
    model_predict();
    @(negedge Clk);
    check_eq("level_a", 32'(lvl_a),  32'(pack_bits(0, 0)));
    check_eq("rise_a",  32'(rise_a), 32'(pack_bits(0, 1)));
    check_eq("fall_a",  32'(fall_a), 32'(pack_bits(0, 2)));
    check_eq("level_b", 32'(lvl_b),  32'(pack_bits(1, 0)));
    check_eq("rise_b",  32'(rise_b), 32'(pack_bits(1, 1)));
    check_eq("fall_b",  32'(fall_b), 32'(pack_bits(1, 2)));
    for (int c = 0; c < N; c++) begin
      rise_cnt[0][c] += int'(rise_a[c]);
      fall_cnt[0][c] += int'(fall_a[c]);
      rise_cnt[1][c] += int'(rise_b[c]);
      fall_cnt[1][c] += int'(fall_b[c]);
    end
  endtask

  function automatic logic obs_lvl(input int d, input int c);
    return (d == 1) ? lvl_b[c] : lvl_a[c];
  endfunction

  // Steps until the observed level reaches val; lat = steps taken or -1.
  task automatic wait_level(input int d, input int c, input logic val, output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (obs_lvl(d, c) === val) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int r0;
    bit seen;

    m_cyc = 0;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < N; c++) begin
        rise_cnt[d][c] = 0;
        fall_cnt[d][c] = 0;
      end

    #2 Reset = 1'b1;
    repeat (3) step();
    check_eq("reset_level_a", 32'(lvl_a), 32'h0);
    check_eq("reset_pulses_a", 32'(rise_a | fall_a), 32'h0);

    // Active-low instance idles high from before reset release.
    raw_b = '1;
    Reset = 1'b0;

    // Single channel press and acceptance.
    raw_a = 4'b0001;
    wait_level(0, 0, 1'b1, lat);
    check_eq("rise0_latency_in_11_15", 32'(lat >= 11 && lat <= 15), 32'h1);
    repeat (5) step();
    check_eq("rise0_count", 32'(rise_cnt[0][0]), 32'd1);
    check_eq("level_a_after_rise0", 32'(lvl_a), 32'h1);
    check_eq("rise_others", 32'(rise_cnt[0][1] + rise_cnt[0][2] + rise_cnt[0][3]), 32'd0);

    // Short glitch on channel 1 must be swallowed.
    raw_a[1] = 1'b1;
    repeat (6) step();
    raw_a[1] = 1'b0;
    repeat (30) step();
    check_eq("glitch1_rise", 32'(rise_cnt[0][1]), 32'd0);
    check_eq("glitch1_fall", 32'(fall_cnt[0][1]), 32'd0);
    check_eq("glitch1_level", 32'(lvl_a[1]), 32'h0);

    // Release of channel 0.
    raw_a[0] = 1'b0;
    wait_level(0, 0, 1'b0, lat);
    check_eq("fall0_latency_in_11_15", 32'(lat >= 11 && lat <= 15), 32'h1);
    repeat (5) step();
    check_eq("fall0_count", 32'(fall_cnt[0][0]), 32'd1);

    // Channels 2 and 3 raised together must pulse together.
    raw_a[3:2] = 2'b11;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (rise_a[2] || rise_a[3]) begin
        seen = 1'b1;
        check_eq("rise23_same_cycle", 32'(rise_a[3:2]), 32'h3);
        break;
      end
    end
    check_eq("rise23_seen", 32'(seen), 32'h1);

    // Reset partway into a wait, then full re-qualification.
    raw_a[0] = 1'b1;
    repeat (8) step();
    r0 = rise_cnt[0][0];
    Reset = 1'b1;
    repeat (2) step();
    check_eq("rst_mid_wait_no_rise", 32'(rise_cnt[0][0]), 32'(r0));
    Reset = 1'b0;
    wait_level(0, 0, 1'b1, lat);
    check_eq("requal_latency_in_11_15", 32'(lat >= 11 && lat <= 15), 32'h1);
    repeat (3) step();
    check_eq("requal_rise_count", 32'(rise_cnt[0][0] - r0), 32'd1);

    // Active-low bank idle-high: nothing so far, then press channel 0.
    check_eq("al_idle_level", 32'(lvl_b), 32'h0);
    check_eq("al_idle_rises", 32'(rise_cnt[1][0] + rise_cnt[1][1] + rise_cnt[1][2] + rise_cnt[1][3]), 32'd0);
    raw_b[0] = 1'b0;
    wait_level(1, 0, 1'b1, lat);
    check_eq("al_rise_latency_in_11_15", 32'(lat >= 11 && lat <= 15), 32'h1);
    repeat (3) step();
    check_eq("al_rise_count", 32'(rise_cnt[1][0]), 32'd1);

    // Random toggling, including a mid-run reset.
    for (int i = 0; i < 700; i++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 11) == 0) raw_a[c] = ~raw_a[c];
        if ($urandom_range(0, 11) == 0) raw_b[c] = ~raw_b[c];
      end
      Reset = (i >= 350 && i < 352);
      step();
    end
    Reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
